gpr_regfile_difftest: RTL and testbench

- Architectural 32x32 integer register file for the NPC core, with two combinational read ports and one write-back port.
- Keeps a commit-aligned snapshot of all 32 GPRs on flattened output s_regs.
- The snapshot feeds the downstream DPI register-export black box, so the C-side difftest sees GPR state only at instruction-commit boundaries, never mid-instruction.
- Counts retired instructions for the difftest step count.

---
 rtl/npc_pkg.sv | 8 +
 rtl/gpr_regfile_difftest_snapshot.sv | 31 +++
 rtl/gpr_regfile_difftest.sv | 61 ++++++
 tb/tb_gpr_regfile_difftest.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared GPR file widths and register type
package npc_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W = 64;
  typedef logic [XLEN-1:0] gpr_t;
endpackage

// File: rtl/gpr_regfile_difftest_snapshot.sv
// gpr_snapshot: commit-aligned GPR snapshot, snapshot PC/pulse and retire counter
module gpr_snapshot
  import npc_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  commit_valid,
  input  gpr_t                  commit_pc,
  input  logic [NREGS*XLEN-1:0] nxt,
  output logic [NREGS*XLEN-1:0] s_regs,
  output logic                  snap_valid,
  output gpr_t                  snap_pc,
  output logic [CNT_W-1:0]      commit_cnt
);
  // capture the merged register view only when an instruction retires
  always_ff @(posedge clock) begin
    if (!reset) begin
      s_regs <= '0;
      snap_valid <= 1'b0;
      snap_pc <= '0;
      commit_cnt <= '0;
    end else begin
      snap_valid <= commit_valid;
      if (commit_valid) begin
        s_regs <= nxt;
        snap_pc <= commit_pc;
        commit_cnt <= commit_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/gpr_regfile_difftest.sv
// gpr_regfile_difftest: 32x32 GPR file with commit snapshot; GPR_WRITE_BYPASS_EN enables write-through reads
module gpr_regfile_difftest
  import npc_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_AW-1:0]     rs1_addr,
  output gpr_t                  rs1_data,
  input  logic [REG_AW-1:0]     rs2_addr,
  output gpr_t                  rs2_data,
  input  logic                  wb_en,
  input  logic [REG_AW-1:0]     wb_addr,
  input  gpr_t                  wb_data,
  input  logic                  commit_valid,
  input  gpr_t                  commit_pc,
  output logic [NREGS*XLEN-1:0] s_regs,
  output logic                  snap_valid,
  output gpr_t                  snap_pc,
  output logic [CNT_W-1:0]      commit_cnt
);
  gpr_t regs [NREGS];
  logic [NREGS*XLEN-1:0] cur;
  logic [NREGS*XLEN-1:0] nxt;
  logic wr;
  assign wr = wb_en && wb_addr != '0;
  for (genvar i = 0; i < NREGS; i++) begin : g_vec
    if (i == 0) begin : g_zero
      assign cur[XLEN-1:0] = '0;
      assign nxt[XLEN-1:0] = '0;
    end else begin : g_reg
      assign cur[i*XLEN +: XLEN] = regs[i];
      assign nxt[i*XLEN +: XLEN] = (wr && wb_addr == REG_AW'(i)) ? wb_data : regs[i];
    end
  end
`ifdef GPR_WRITE_BYPASS_EN
  assign rs1_data = nxt[rs1_addr*XLEN +: XLEN];
  assign rs2_data = nxt[rs2_addr*XLEN +: XLEN];
`else
  assign rs1_data = cur[rs1_addr*XLEN +: XLEN];
  assign rs2_data = cur[rs2_addr*XLEN +: XLEN];
`endif
  // architectural write-back; x0 is never written
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else if (wr) begin
      regs[wb_addr] <= wb_data;
    end
  end
  gpr_snapshot u_snap (
    .clock(clock),
    .reset(reset),
    .commit_valid(commit_valid),
    .commit_pc(commit_pc),
    .nxt(nxt),
    .s_regs(s_regs),
    .snap_valid(snap_valid),
    .snap_pc(snap_pc),
    .commit_cnt(commit_cnt)
  );
endmodule

// File: tb/tb_gpr_regfile_difftest.sv
// tb_gpr_regfile_difftest: scoreboard bench for the commit-aligned GPR file
module tb_gpr_regfile_difftest;
  typedef logic [1023:0] w_t;
  typedef struct {
    logic [1023:0] regs;
    logic [31:0] pc;
  } snap_t;
  logic clock;
  logic reset;
  logic [4:0] rs1_addr, rs2_addr, wb_addr;
  logic [31:0] rs1_data, rs2_data, wb_data, commit_pc, snap_pc;
  logic wb_en, commit_valid, snap_valid;
  logic [1023:0] s_regs;
  logic [63:0] commit_cnt;
  logic [31:0] m [32];
  logic [63:0] cnt;
  logic [1023:0] last;
  logic [31:0] lpc;
  snap_t q[$];
  int n_cmp, n_bad, run;
  gpr_regfile_difftest dut (
    .clock(clock), .reset(reset),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .s_regs(s_regs), .snap_valid(snap_valid), .snap_pc(snap_pc),
    .commit_cnt(commit_cnt)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input w_t got, input w_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rexp(input logic [4:0] a, input bit we, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
`ifdef GPR_WRITE_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m[a];
  endfunction
  function automatic logic [1023:0] pack();
    logic [1023:0] s;
    for (int i = 0; i < 32; i++) s[32*i +: 32] = (i == 0) ? 32'h0 : m[i];
    return s;
  endfunction
  task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd, input bit cv, input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2);
    snap_t e;
    wb_en = we; wb_addr = wa; wb_data = wd;
    commit_valid = cv; commit_pc = pc;
    rs1_addr = a1; rs2_addr = a2;
    #1;
    chk("rs1_data", w_t'(rs1_data), w_t'(rexp(a1, we, wa, wd)));
    chk("rs2_data", w_t'(rs2_data), w_t'(rexp(a2, we, wa, wd)));
    @(posedge clock);
    #1;
    if (we && wa != 5'd0) m[wa] = wd;
    if (cv) begin
      cnt = cnt + 64'd1;
      e.regs = pack();
      e.pc = pc;
      q.push_back(e);
    end
    chk("snap_valid", w_t'(snap_valid), w_t'(cv));
    if (snap_valid) begin
      if (q.size() == 0) chk("sb_underflow", w_t'(1), w_t'(0));
      else begin
        e = q.pop_front();
        last = e.regs;
        lpc = e.pc;
      end
    end
    chk("s_regs", w_t'(s_regs), w_t'(last));
    chk("snap_pc", w_t'(snap_pc), w_t'(lpc));
    chk("commit_cnt", w_t'(commit_cnt), w_t'(cnt));
  endtask
  task automatic do_reset(input bit cv);
    reset = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD;
    commit_valid = cv; commit_pc = 32'h8000_0000;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    cnt = 64'd0; last = '0; lpc = 32'h0;
    q.delete();
    chk("rst_snap_valid", w_t'(snap_valid), w_t'(0));
    chk("rst_s_regs", w_t'(s_regs), w_t'(0));
    chk("rst_commit_cnt", w_t'(commit_cnt), w_t'(0));
    chk("rst_snap_pc", w_t'(snap_pc), w_t'(0));
    reset = 1'b1;
    wb_en = 1'b0; commit_valid = 1'b0;
  endtask
  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    commit_valid = 1'b0; commit_pc = '0; rs1_addr = '0; rs2_addr = '0;
    do_reset(1'b0);
    step(0, 0, 0, 0, 0, 5, 0);
    step(1, 0, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 0);
    chk("x0_slice", w_t'(s_regs[31:0]), w_t'(0));
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 3, 32'h1234, 1, 32'h8000_0004, 3, 0);
    chk("x3_slice", w_t'(s_regs[127:96]), w_t'(32'h1234));
    chk("x3_pc", w_t'(snap_pc), w_t'(32'h8000_0004));
    step(0, 0, 0, 0, 0, 3, 3);
    step(1, 7, 32'hAA, 0, 0, 0, 0);
    chk("x7_held", w_t'(s_regs[255:224]), w_t'(0));
    step(0, 0, 0, 1, 32'h8000_0008, 7, 0);
    chk("x7_rd", w_t'(rs1_data), w_t'(32'hAA));
    chk("x7_slice", w_t'(s_regs[255:224]), w_t'(32'hAA));
    step(1, 10, 32'h55, 0, 0, 0, 10);
    step(0, 0, 0, 0, 0, 10, 10);
    do_reset(1'b1);
    run = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 5'(i + 1), 32'h100 + i, 1, 32'h8000_0100 + 4 * i, 5'(i), 5'(i + 1));
      if (snap_valid) run++;
    end
    chk("b2b_run", w_t'(run), w_t'(5));
    chk("b2b_cnt", w_t'(commit_cnt), w_t'(5));
    step(0, 0, 0, 0, 0, 1, 2);
    force dut.u_snap.commit_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_snap.commit_cnt;
    cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    step(0, 0, 0, 1, 32'h8000_0200, 0, 0);
    chk("cnt_wrap", w_t'(commit_cnt), w_t'(0));
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 1'($urandom_range(0, 1)), $urandom, 5'($urandom), 5'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
